// File: rtl/wb_ascon_blkbuf_pkg.sv
// Shared types and helpers for the ASCON input block buffer.
package ascon_buf_pkg;

  // One queued 64-bit ASCON block with its metadata.
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  len;
    logic        ad;
    logic        last;
  } blk_entry_t;

  // Staging FSM: S_HALF holds the upper word of a block still being packed.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } stage_state_t;

  // Legal left-aligned byte-enable patterns; SEL_NONE is legal only with wr_last.
  localparam logic [3:0] SEL_B1   = 4'b1000;
  localparam logic [3:0] SEL_B2   = 4'b1100;
  localparam logic [3:0] SEL_B3   = 4'b1110;
  localparam logic [3:0] SEL_B4   = 4'b1111;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  // Number of enabled bytes in a word.
  function automatic logic [3:0] sel_len(input logic [3:0] sel);
    return {3'b000, sel[3]} + {3'b000, sel[2]} + {3'b000, sel[1]} + {3'b000, sel[0]};
  endfunction

  // Byte mask so that disabled bytes land in the block as zero.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_ascon_blkbuf_if.sv
// Bus-side and core-side signals of the block buffer.
// Handshake: a bus word is taken on the cycle wr_en && wr_ready (and a legal
// wr_sel); a block leaves the head on the cycle rd_valid && rd_ready. rd_* is
// a combinational view of the head and does not depend on rd_ready.
interface wb_ascon_blkbuf_if
  import ascon_buf_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [31:0]      wr_data;
  logic [3:0]       wr_sel;
  logic             wr_ad;
  logic             wr_last;
  logic             wr_ready;
  logic             rd_valid;
  logic             rd_ready;
  logic [63:0]      rd_block;
  logic [3:0]       rd_len;
  logic             rd_ad;
  logic             rd_last;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;
  stage_state_t     stage_state;

  modport master (
    output wr_en, wr_data, wr_sel, wr_ad, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_block, rd_len, rd_ad, rd_last,
    input  count, full, empty, err, stage_state
  );

  modport slave (
    input  wr_en, wr_data, wr_sel, wr_ad, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_block, rd_len, rd_ad, rd_last,
    output count, full, empty, err, stage_state
  );
endinterface

// File: rtl/wb_ascon_blkbuf_fifo.sv
// Synchronous FIFO of block entries; full/empty come from the count.
module ascon_sync_fifo
  import ascon_buf_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = blk_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             clear,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  // Head reads as zero while empty so rd_* is clean after reset or drain.
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_ascon_blkbuf.sv
// Packs 32-bit bus words into 64-bit ASCON blocks and queues them for the core.
module wb_ascon_blkbuf
  import ascon_buf_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               clear,
  wb_ascon_blkbuf_if.slave   bus
);

  stage_state_t     state;
  stage_state_t     state_next;
  logic [31:0]      half_word;
  logic             half_ad;
  logic             load_half;
  logic             push;
  blk_entry_t       push_entry;
  blk_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             sel_ok;
  logic             accept;
  logic             drop;
  logic [31:0]      word;
  logic             err;

  // Word qualification: legal byte enables and room in the queue.
  always_comb begin
    sel_ok = (bus.wr_sel == SEL_B1) || (bus.wr_sel == SEL_B2) ||
             (bus.wr_sel == SEL_B3) || (bus.wr_sel == SEL_B4) ||
             ((bus.wr_sel == SEL_NONE) && bus.wr_last);
    accept = bus.wr_en && !fifo_full && sel_ok;
    drop   = bus.wr_en && !accept;
    word   = bus.wr_data & sel_mask(bus.wr_sel);
  end

  // Staging next-state and block assembly; a block's tag comes from its first word.
  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      case (state)
        S_EMPTY: begin
          if ((bus.wr_sel == SEL_B4) && !bus.wr_last) begin
            load_half  = 1'b1;
            state_next = S_HALF;
          end else begin
            push            = 1'b1;
            push_entry.data = {word, 32'h0};
            push_entry.len  = sel_len(bus.wr_sel);
            push_entry.ad   = bus.wr_ad;
            push_entry.last = bus.wr_last;
          end
        end
        S_HALF: begin
          push            = 1'b1;
          push_entry.data = {half_word, word};
          push_entry.len  = 4'd4 + sel_len(bus.wr_sel);
          push_entry.ad   = half_ad;
          push_entry.last = bus.wr_last;
          state_next      = S_EMPTY;
        end
        default: state_next = S_EMPTY;
      endcase
    end
  end

  // Staging state register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)      state <= S_EMPTY;
    else if (clear) state <= S_EMPTY;
    else            state <= state_next;
  end

  // Upper half of a block awaiting its second word.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      half_word <= '0;
      half_ad   <= 1'b0;
    end else if (clear) begin
      half_word <= '0;
      half_ad   <= 1'b0;
    end else if (load_half) begin
      half_word <= word;
      half_ad   <= bus.wr_ad;
    end
  end

  // Sticky error for any dropped write.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)      err <= 1'b0;
    else if (clear) err <= 1'b0;
    else if (drop)  err <= 1'b1;
  end

  ascon_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (blk_entry_t)
  ) u_fifo (
    .clk       (clk),
    .nRST      (nRST),
    .clear     (clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (bus.rd_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.wr_ready    = !fifo_full;
  assign bus.rd_valid    = !fifo_empty;
  assign bus.rd_block    = head.data;
  assign bus.rd_len      = head.len;
  assign bus.rd_ad       = head.ad;
  assign bus.rd_last     = head.last;
  assign bus.count       = fifo_count;
  assign bus.full        = fifo_full;
  assign bus.empty       = fifo_empty;
  assign bus.err         = err;
  assign bus.stage_state = state;

endmodule

// File: doc/wb_ascon_blkbuf.md
Name: wb_ascon_blkbuf

Overview:
- Parametrised input block buffer between the Wishbone slave and the ASCON_AEAD core.
- Replaces the fixed mem_block/AD_loader pair with one buffer. It packs 32-bit bus words into 64-bit ASCON blocks, with per-block byte length, AD/message tag and last flag.
- Queues up to DEPTH blocks so the host can stream ahead of the core.
- The core drains blocks through a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO depth in 64-bit blocks; power of two, >=2.
- CNT_W, $clog2(DEPTH+1), width of fill count (derived, not overridden).

Ports:
- clk  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of FIFO, staging register and error flags.
- wr_en  in  1  bus word write strobe.
- wr_data  in  32  word; byte i at wr_data[31-8i -: 8].
- wr_sel  in  4  byte enables, left-aligned: 1000, 1100, 1110, 1111, or 0000 only with wr_last.
- wr_ad  in  1  word belongs to associated data (1) or message (0).
- wr_last  in  1  final word of current AD or message segment.
- wr_ready  out  1  buffer can accept a word this cycle.
- rd_valid  out  1  head block available.
- rd_ready  in  1  core consumes head block.
- rd_block  out  64  head block data, first byte in [63:56], unused bytes zero.
- rd_len  out  4  valid bytes in rd_block, 0..8.
- rd_ad  out  1  head block is AD.
- rd_last  out  1  head block is last of its segment.
- count  out  CNT_W  blocks currently queued.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  1  sticky: dropped write (overflow or illegal wr_sel).

Behaviour:
- Reset (nRST low, async):
  - Pointers, count and staging state cleared.
  - rd_valid=0, rd_block=0, rd_len=0, rd_ad=0, rd_last=0, count=0, full=0, empty=1, err=0, wr_ready=1.
- Staging FSM, states S_EMPTY and S_HALF:
  - S_EMPTY with accepted word, full (sel=1111) and !wr_last: store word in [63:32], latch wr_ad, len=4, go to S_HALF.
  - S_EMPTY with accepted word, partial or wr_last: push block (word in [63:32], [31:0]=0, len=popcount(sel), last=wr_last). Stay in S_EMPTY.
  - S_HALF with accepted word: place it in [31:0], len=4+popcount(sel), last=wr_last, push, go to S_EMPTY.
  - In S_HALF, the second word's wr_ad is ignored; the block's tag comes from the first word.
  - sel=0000 with wr_last in S_EMPTY pushes a zero-length last block (padding-only block); in S_HALF it pushes len=4 with last=1.
  - A partial word (sel != 1111) without wr_last in S_EMPTY still closes the block; last=0.
- Write acceptance:
  - wr_ready = !full, including in S_HALF. There is no same-cycle push/pop bypass when full.
  - A write with wr_en=1 and wr_ready=0 is dropped and sets err; state is unchanged.
  - An illegal wr_sel (not in the legal set, or 0000 without wr_last) is dropped and sets err.
- Read:
  - rd_* is a combinational view of the head entry; rd_valid = !empty.
  - Pop on rd_valid && rd_ready. rd_ready while empty is ignored.
  - A pushed block is visible on rd_* the cycle after its closing write.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full and empty are derived from count, not from pointer equality.
- clear has priority over same-cycle writes and pops. The next cycle shows the reset values; err is also cleared.
- Asserting nRST mid-block discards staging contents without pushing.
- No data-dependent stall: push and pop each complete in one cycle.

Decomposition:
- Package ascon_buf_pkg holds:
  - typedef blk_entry_t struct {logic [63:0] data; logic [3:0] len; logic ad; logic last;}
  - typedef stage_state_t enum {S_EMPTY, S_HALF}
  - Constants for the legal wr_sel patterns.
- Sub-module ascon_sync_fifo, parametrised on DEPTH and entry type, holds storage, pointers and count.
- wb_ascon_blkbuf itself holds the staging FSM, packing, sel checks and error logic.

Test Plan:
1. AD 0x0001020304050607 as two writes (sel=1111), second with wr_last, wr_ad=1 -> one block: rd_block=0x0001020304050607, rd_len=8, rd_ad=1, rd_last=1, count=1.
2. Message: words 0xAABBCCDD (1111) then 0xEEFF0000 (1100, wr_last), wr_ad=0 -> rd_block=0xAABBCCDDEEFF0000, rd_len=6, rd_last=1.
3. wr_sel=0000 with wr_last in S_EMPTY -> block with rd_len=0, rd_block=0, rd_last=1. Then wr_sel=0110 -> dropped, err=1, count unchanged.
4. Fill DEPTH=8 blocks with rd_ready=0 -> full=1, wr_ready=0. A 9th write is dropped and err=1. Then pop all 8 -> data in order, empty=1.
5. When count=3, hold wr_en (pushing) and rd_ready=1 for 10 cycles -> count stays 3, pointers wrap, FIFO order preserved.
6. Write the first half of a block (S_HALF) with 2 blocks queued, then pulse clear together with wr_en and rd_ready -> next cycle count=0, empty=1, err=0, staging empty. A following single write with wr_last yields len=4.
